// File: rtl/path_feed_ctrl.sv
// Path-memory sequencer: streams one day of samples per pass (first pass + replay) into the pricer.
// Optional back-pressure via `PATH_FEED_STALL_EN` (adds feed_ready and credit-throttled reads).
module path_feed_ctrl #(
  parameter int DATA_W        = 12,
  parameter int PATHS_PER_DAY = 256,
  parameter int NUM_DAYS      = 64,
  parameter int ADDR_W        = 14,
  localparam int DAY_W = (NUM_DAYS > 1) ? $clog2(NUM_DAYS) : 1,
  localparam int IDX_W = (PATHS_PER_DAY > 1) ? $clog2(PATHS_PER_DAY) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              resend,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              feed_valid,
  output logic [DATA_W-1:0] feed_data,
  output logic              feed_first,
  output logic              feed_last,
  output logic              pass,
  output logic [DAY_W-1:0]  day,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef PATH_FEED_STALL_EN
  ,
  input  logic              feed_ready
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_WAIT_RS} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              first;
    logic              last;
  } entry_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DAY_W-1:0]  day_q, day_d;
  logic              pass_q, pass_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_first_q, rd_first_d;
  logic              rd_last_q, rd_last_d;
  logic              pend_q, pend_d;
  logic              pend_first_q, pend_first_d;
  logic              pend_last_q, pend_last_d;
  entry_t            e0_q, e0_d;
  entry_t            e1_q, e1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;

  logic              ready;
  logic              pop;
  logic              push;
  logic              permit;
  entry_t            new_e;
  logic [ADDR_W-1:0] base;

`ifdef PATH_FEED_STALL_EN
  logic [1:0] occ;
  assign ready = feed_ready;
`else
  assign ready = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    day_d        = day_q;
    pass_d       = pass_q;
    err_d        = err_q;
    done_d       = 1'b0;
    rd_en_d      = 1'b0;
    addr_d       = addr_q;
    rd_first_d   = 1'b0;
    rd_last_d    = 1'b0;
    e0_d         = e0_q;
    e1_d         = e1_q;
    cnt_d        = cnt_q;

    // Tags travel with each read so the flags line up with the returned data.
    pend_d       = rd_en_q;
    pend_first_d = rd_first_q;
    pend_last_d  = rd_last_q;

    pop   = valid_q & ready;
    push  = pend_q;
    new_e = '{data: mem_rdata, first: pend_first_q, last: pend_last_q};

    // Head slot e0 drives the outputs directly; an empty slot is kept at zero.
    if (pop && push) begin
      if (cnt_q == 2'd2) begin
        e0_d = e1_q;
        e1_d = new_e;
      end else begin
        e0_d = new_e;
      end
    end else if (pop) begin
      e0_d  = e1_q;
      e1_d  = '0;
      cnt_d = cnt_q - 2'd1;
    end else if (push) begin
      if (cnt_q == 2'd0) e0_d = new_e;
      else               e1_d = new_e;
      cnt_d = cnt_q + 2'd1;
    end

`ifdef PATH_FEED_STALL_EN
    // Reserve a slot for every read still in the memory pipeline before issuing another.
    occ    = cnt_d + {1'b0, rd_en_q};
    permit = (occ < 2'd2);
`else
    permit = 1'b1;
`endif

    base = ADDR_W'(day_q) * ADDR_W'(PATHS_PER_DAY);

    if (resend && (state_q != S_WAIT_RS)) err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          day_d   = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (permit) begin
          rd_en_d    = 1'b1;
          addr_d     = base + ADDR_W'(idx_q);
          rd_first_d = (idx_q == '0);
          rd_last_d  = (idx_q == IDX_W'(PATHS_PER_DAY - 1));
          if (idx_q == IDX_W'(PATHS_PER_DAY - 1)) begin
            idx_d   = '0;
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (pop && e0_q.last) state_d = S_WAIT_RS;
      end
      S_WAIT_RS: begin
        if (resend) begin
          idx_d = '0;
          if (!pass_q) begin
            pass_d  = 1'b1;
            state_d = S_STREAM;
          end else if (day_q != DAY_W'(NUM_DAYS - 1)) begin
            pass_d  = 1'b0;
            day_d   = day_q + DAY_W'(1);
            state_d = S_STREAM;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = (cnt_d != 2'd0);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      day_q        <= '0;
      pass_q       <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      rd_first_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_first_q <= 1'b0;
      pend_last_q  <= 1'b0;
      e0_q         <= '0;
      e1_q         <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      day_q        <= day_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      rd_first_q   <= rd_first_d;
      rd_last_q    <= rd_last_d;
      pend_q       <= pend_d;
      pend_first_q <= pend_first_d;
      pend_last_q  <= pend_last_d;
      e0_q         <= e0_d;
      e1_q         <= e1_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
    end
  end

  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign feed_valid = valid_q;
  assign feed_data  = e0_q.data;
  assign feed_first = e0_q.first;
  assign feed_last  = e0_q.last;
  assign pass       = pass_q;
  assign day        = day_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_path_feed_ctrl.sv
// Directed bench for path_feed_ctrl with PATHS_PER_DAY=4, NUM_DAYS=2 and a mem[a]=a memory model.
module tb_path_feed_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        resend;
  logic        mem_rd_en;
  logic [3:0]  mem_addr;
  logic [11:0] mem_rdata = '0;
  logic        feed_valid;
  logic [11:0] feed_data;
  logic        feed_first;
  logic        feed_last;
  logic        pass;
  logic [0:0]  day;
  logic        busy;
  logic        done;
  logic        err;
  logic        rdy;
`ifdef PATH_FEED_STALL_EN
  logic        feed_ready;
  assign rdy = feed_ready;
`else
  assign rdy = 1'b1;
`endif

  int tests = 0;
  int fails = 0;

  path_feed_ctrl #(
    .DATA_W(12), .PATHS_PER_DAY(4), .NUM_DAYS(2), .ADDR_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resend(resend),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .feed_valid(feed_valid), .feed_data(feed_data),
    .feed_first(feed_first), .feed_last(feed_last),
    .pass(pass), .day(day), .busy(busy), .done(done), .err(err)
`ifdef PATH_FEED_STALL_EN
    , .feed_ready(feed_ready)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= 12'(mem_addr);

  typedef struct packed {
    logic [11:0] data;
    logic        first;
    logic        last;
    logic        pass;
    logic        day;
  } vec_t;

  vec_t       exp_t[16];
  vec_t       got_q[$];
  logic [3:0] addr_q[$];

  // Every accepted sample (valid && ready) and every issued read address is logged.
  always @(negedge clk) begin
    if (rst_n && feed_valid && rdy) got_q.push_back('{feed_data, feed_first, feed_last, pass, day[0]});
    if (rst_n && mem_rd_en) addr_q.push_back(mem_addr);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // poke: 0 none, 1 start pulse mid-stream, 2 resend pulse mid-stream
  task automatic do_pass(input bit use_start, input bit final_pass, input int poke);
    int lat;
    int n;
    if (use_start) start = 1'b1;
    else           resend = 1'b1;
    step();
    start  = 1'b0;
    resend = 1'b0;
    if (final_pass) begin
      chk("done_pulse", done, 1);
      chk("busy_drop", busy, 0);
      step();
      chk("done_one_cycle", done, 0);
      return;
    end
    chk("done_quiet", done, 0);
    lat = 0;
    while (!feed_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("first_valid_latency", lat, 3);
    chk("first_flag", feed_first, 1);
    if (poke == 1) start = 1'b1;
    if (poke == 2) resend = 1'b1;
    n = 0;
    while (!feed_last && n < 50) begin
      step();
      start  = 1'b0;
      resend = 1'b0;
      n++;
    end
    chk("last_seen", feed_last, 1);
`ifndef PATH_FEED_STALL_EN
    chk("pass_span_cycles", n, 3);
`endif
    step();
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_sample_count"}, got_q.size(), 16);
    chk({tag, "_addr_count"}, addr_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("%s_data[%0d]", tag, i), got_q[i].data, exp_t[i].data);
        chk($sformatf("%s_flags_fl_pass_day[%0d]", tag, i),
            {got_q[i].first, got_q[i].last, got_q[i].pass, got_q[i].day},
            {exp_t[i].first, exp_t[i].last, exp_t[i].pass, exp_t[i].day});
      end
      if (i < addr_q.size()) chk($sformatf("%s_addr[%0d]", tag, i), addr_q[i], exp_t[i].data);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    addr_q.delete();
  endtask

  initial begin
    logic [11:0] hold;
    int lat;
    int n;

    //          data   first last  pass  day
    exp_t[0]  = '{12'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t[1]  = '{12'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[2]  = '{12'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[3]  = '{12'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t[4]  = '{12'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t[5]  = '{12'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t[6]  = '{12'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t[7]  = '{12'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_t[8]  = '{12'd4, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_t[9]  = '{12'd5, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t[10] = '{12'd6, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t[11] = '{12'd7, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_t[12] = '{12'd4, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_t[13] = '{12'd5, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t[14] = '{12'd6, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t[15] = '{12'd7, 1'b0, 1'b1, 1'b1, 1'b1};

    rst_n  = 1'b0;
    start  = 1'b0;
    resend = 1'b0;
`ifdef PATH_FEED_STALL_EN
    feed_ready = 1'b1;
`endif
    step();
    step();
    chk("reset_outputs_zero",
        {mem_rd_en, mem_addr, feed_valid, feed_data, feed_first, feed_last, pass, day, busy, done, err}, 0);
    rst_n = 1'b1;
    step();

    // Full run with a start pulse injected mid-stream of the first pass
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("no_read_first_cycle", mem_rd_en, 0);
    step();
    chk("first_read_en", mem_rd_en, 1);
    chk("first_read_addr", mem_addr, 0);
    chk("no_valid_yet", feed_valid, 0);
    lat = 1;
    while (!feed_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("start_to_valid", lat, 3);
    start = 1'b1;
    n = 0;
    while (!feed_last && n < 50) begin
      step();
      start = 1'b0;
      n++;
    end
    step();
    do_pass(0, 0, 0);
    do_pass(0, 0, 0);
    do_pass(0, 0, 0);
    do_pass(0, 1, 0);
    chk("run1_err_clear", err, 0);
    check_run("run1");

    // Run with a resend injected mid-stream: stream unaffected, err sticky
    clear_logs();
    do_pass(1, 0, 2);
    chk("err_set_by_resend", err, 1);
    do_pass(0, 0, 0);
    do_pass(0, 0, 0);
    do_pass(0, 0, 0);
    do_pass(0, 1, 0);
    chk("err_sticky_after_done", err, 1);
    check_run("run2");

    clear_logs();
    do_pass(1, 0, 0);
    chk("err_cleared_by_start", err, 0);

    // Reset asserted during pass 1 of day 0
    resend = 1'b1;
    step();
    resend = 1'b0;
    step();
    step();
    chk("in_replay_pass", pass, 1);
    chk("replay_reading", mem_rd_en, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_zero",
        {mem_rd_en, mem_addr, feed_valid, feed_data, feed_first, feed_last, pass, day, busy, done, err}, 0);
    step();
    rst_n = 1'b1;
    step();
    clear_logs();
    do_pass(1, 0, 0);
    chk("restart_addr0", (addr_q.size() > 0) ? 32'(addr_q[0]) : 32'hDEAD, 0);
    chk("restart_sample0",
        (got_q.size() > 0) ? 32'({got_q[0].data, got_q[0].first, got_q[0].pass, got_q[0].day}) : 32'hDEAD,
        32'({12'd0, 1'b1, 1'b0, 1'b0}));

`ifdef PATH_FEED_STALL_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!feed_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("stall_run_latency", lat, 3);
    step();
    feed_ready = 1'b0;
    hold = feed_data;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("stall_hold[%0d]", i), feed_data, hold);
      chk($sformatf("stall_valid[%0d]", i), feed_valid, 1);
      if (i >= 2) chk($sformatf("stall_no_read[%0d]", i), mem_rd_en, 0);
    end
    feed_ready = 1'b1;
    n = 0;
    while (!feed_last && n < 50) begin
      step();
      n++;
    end
    step();
    do_pass(0, 0, 0);
    do_pass(0, 0, 0);
    do_pass(0, 0, 0);
    do_pass(0, 1, 0);
    check_run("stall");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
